// File: rtl/uart_cmd_parser.sv
// Frame decoder behind the UART receiver: SYNC, CMD, LEN, payload, XOR checksum -> valid/ready command.
// Optional inter-byte timeout is compiled in when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_parser #(
  parameter int unsigned  MAX_PAYLOAD    = 8,
  parameter logic [7:0]   SYNC_BYTE      = 8'hA5,
  parameter int unsigned  TIMEOUT_CYCLES = 50000,
  localparam int unsigned LEN_W          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_RX_DV,
  input  logic [7:0]               i_RX_Byte,
  output logic                     o_cmd_valid,
  input  logic                     i_cmd_ready,
  output logic [7:0]               o_cmd,
  output logic [LEN_W-1:0]         o_len,
  output logic [8*MAX_PAYLOAD-1:0] o_payload,
  output logic                     o_chk_err,
  output logic                     o_drop,
  output logic                     o_timeout
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               cmd_q, cmd_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         idx_q, idx_d;
  logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
  logic [7:0]               chk_q, chk_d;
  logic                     valid_q, valid_d;
  logic                     chk_err_q, chk_err_d;
  logic                     drop_q, drop_d;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    chk_d     = chk_q;
    chk_err_d = 1'b0;
    drop_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_RX_DV && i_RX_Byte == SYNC_BYTE) state_d = S_CMD;
      end
      S_CMD: begin
        if (i_RX_DV) begin
          cmd_d     = i_RX_Byte;
          chk_d     = i_RX_Byte;
          payload_d = '0;
          state_d   = S_LEN;
        end
      end
      S_LEN: begin
        if (i_RX_DV) begin
          if (i_RX_Byte > MAX_LEN_B) begin
            drop_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            len_d   = i_RX_Byte[LEN_W-1:0];
            chk_d   = chk_q ^ i_RX_Byte;
            idx_d   = '0;
            state_d = (i_RX_Byte == 8'd0) ? S_CHK : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_RX_DV) begin
          // Constant part-selects decoded from idx keep the write port free of variable-width indexing.
          for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (idx_q == LEN_W'(k)) payload_d[8*k +: 8] = i_RX_Byte;
          end
          chk_d = chk_q ^ i_RX_Byte;
          idx_d = idx_q + LEN_W'(1);
          if (idx_q + LEN_W'(1) == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == chk_q) begin
            state_d = S_HOLD;
          end else begin
            chk_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (i_RX_DV)     drop_d  = 1'b1;
        if (i_cmd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_CMD_TIMEOUT_EN
    // A byte arriving in the expiry cycle takes precedence over the timeout.
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (!i_RX_DV && state_q inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK}) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif

    valid_d = (state_d == S_HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      payload_q <= '0;
      chk_q     <= '0;
      valid_q   <= 1'b0;
      chk_err_q <= 1'b0;
      drop_q    <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      payload_q <= payload_d;
      chk_q     <= chk_d;
      valid_q   <= valid_d;
      chk_err_q <= chk_err_d;
      drop_q    <= drop_d;
`ifdef UART_CMD_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_cmd_valid = valid_q;
  assign o_cmd       = cmd_q;
  assign o_len       = len_q;
  assign o_payload   = payload_q;
  assign o_chk_err   = chk_err_q;
  assign o_drop      = drop_q;

`ifdef UART_CMD_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  // No counter in this build; the timeout parameter is only referenced to keep it visible.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign o_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames with literal expectations,
// then randomized traffic compared every cycle against a byte-queue frame model.
module tb_uart_cmd_parser;

  localparam int unsigned MAXP = 8;
  localparam int unsigned TO   = 100;
  localparam int unsigned LW   = $clog2(MAXP + 1);
  localparam logic [7:0]  SYNC = 8'hA5;
`ifdef UART_CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_RX_DV = 1'b0;
  logic [7:0]          i_RX_Byte = 8'h00;
  logic                i_cmd_ready = 1'b1;
  logic                o_cmd_valid;
  logic [7:0]          o_cmd;
  logic [LW-1:0]       o_len;
  logic [8*MAXP-1:0]   o_payload;
  logic                o_chk_err, o_drop, o_timeout;

  int checks = 0;
  int failures = 0;
  bit rand_ready = 1'b0;

  uart_cmd_parser #(
    .MAX_PAYLOAD   (MAXP),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_RX_DV    (i_RX_DV),
    .i_RX_Byte  (i_RX_Byte),
    .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(i_cmd_ready),
    .o_cmd      (o_cmd),
    .o_len      (o_len),
    .o_payload  (o_payload),
    .o_chk_err  (o_chk_err),
    .o_drop     (o_drop),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the bytes after SYNC in a queue and judges the frame by its size.
  logic [7:0]        frame[$];
  bit                in_frame, hold, armed, e_rst;
  int                idle_cnt;
  logic              e_valid, e_chk_err, e_drop, e_timeout;
  logic [7:0]        e_cmd, e_len, x;
  logic [8*MAXP-1:0] e_pl;

  always @(posedge clk) begin
    e_chk_err = 1'b0;
    e_drop    = 1'b0;
    e_timeout = 1'b0;
    e_rst     = 1'b0;
    if (rst) begin
      in_frame = 1'b0;
      hold     = 1'b0;
      frame.delete();
      idle_cnt = 0;
      e_cmd    = '0;
      e_len    = '0;
      e_pl     = '0;
      e_rst    = 1'b1;
    end else if (hold) begin
      if (i_RX_DV) e_drop = 1'b1;
      if (i_cmd_ready) hold = 1'b0;
    end else if (in_frame) begin
      if (i_RX_DV) begin
        idle_cnt = 0;
        frame.push_back(i_RX_Byte);
        if (frame.size() == 2 && int'(frame[1]) > int'(MAXP)) begin
          e_drop   = 1'b1;
          in_frame = 1'b0;
        end else if (frame.size() >= 2 && frame.size() == int'(frame[1]) + 3) begin
          x = 8'h00;
          for (int k = 0; k < frame.size() - 1; k++) x ^= frame[k];
          if (x == frame[frame.size()-1]) begin
            hold  = 1'b1;
            e_cmd = frame[0];
            e_len = frame[1];
            e_pl  = '0;
            for (int k = 0; k < int'(frame[1]); k++) e_pl[8*k +: 8] = frame[2+k];
          end else begin
            e_chk_err = 1'b1;
          end
          in_frame = 1'b0;
        end
      end else if (TO_EN) begin
        idle_cnt++;
        if (idle_cnt == TO) begin
          e_timeout = 1'b1;
          in_frame  = 1'b0;
        end
      end
    end else if (i_RX_DV && i_RX_Byte == SYNC) begin
      in_frame = 1'b1;
      frame.delete();
      idle_cnt = 0;
    end
    e_valid = hold;
    armed   = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_valid",   o_cmd_valid, e_valid);
      check("model_chk_err", o_chk_err,   e_chk_err);
      check("model_drop",    o_drop,      e_drop);
      check("model_timeout", o_timeout,   e_timeout);
      if (e_valid || e_rst) begin
        check("model_cmd",     o_cmd,     e_cmd);
        check("model_len",     o_len,     e_len);
        check("model_payload", o_payload, e_pl);
      end
    end
  end

  task automatic cyc(input logic dv, input logic [7:0] b);
    i_RX_DV   = dv;
    i_RX_Byte = b;
    if (rand_ready) i_cmd_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    i_RX_DV = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00);
  endtask

  task automatic send_basic();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] c,
                           input logic [LW-1:0] l, input logic [63:0] p);
    check({tag, "_valid"},   o_cmd_valid, v);
    check({tag, "_cmd"},     o_cmd,       c);
    check({tag, "_len"},     o_len,       l);
    check({tag, "_payload"}, o_payload,   p);
  endtask

  logic [7:0] q[$];
  int         kind, len, gap;
  logic [7:0] c8;

  initial begin
    // Reset state
    idle(2);
    rst = 1'b0;
    check_out("reset", 1'b0, 8'h00, '0, 64'h0);
    check("reset_pulses", {o_chk_err, o_drop, o_timeout}, 3'b000);

    // Basic frame with ready high: valid for exactly one cycle
    i_cmd_ready = 1'b1;
    send_basic();
    check_out("basic", 1'b1, 8'h10, LW'(2), 64'h2211);
    idle(1);
    check("basic_accepted", o_cmd_valid, 1'b0);

    // Leading garbage then zero-length frame
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h05); send(8'h00); send(8'h05);
    check_out("zero_len", 1'b1, 8'h05, LW'(0), 64'h0);
    idle(1);

    // Bad checksum, then a correct frame right after
    send(8'hA5); send(8'h10); send(8'h01); send(8'h33); send(8'h00);
    check("bad_chk_pulse", o_chk_err, 1'b1);
    check("bad_chk_valid", o_cmd_valid, 1'b0);
    send(8'hA5); send(8'h10); send(8'h01); send(8'h33); send(8'h22);
    check_out("good_after_bad", 1'b1, 8'h10, LW'(1), 64'h33);
    idle(1);

    // Oversize length
    send(8'hA5); send(8'h01); send(8'h09);
    check("oversize_drop", o_drop, 1'b1);
    idle(1);
    check("oversize_drop_one_cycle", o_drop, 1'b0);

    // Backpressure: stray byte while holding is dropped, outputs stay put
    i_cmd_ready = 1'b0;
    send_basic();
    idle(2);
    send(8'h55);
    check("hold_drop", o_drop, 1'b1);
    check_out("hold_stable", 1'b1, 8'h10, LW'(2), 64'h2211);
    i_cmd_ready = 1'b1;
    idle(1);
    check("hold_released", o_cmd_valid, 1'b0);

    // Inter-byte timeout
    send(8'hA5); send(8'h10);
    idle(TO);
`ifdef UART_CMD_TIMEOUT_EN
    check("timeout_pulse", o_timeout, 1'b1);
    idle(1);
    send_basic();
`else
    check("no_timeout_pulse", o_timeout, 1'b0);
    send(8'h02); send(8'h11); send(8'h22); send(8'h21);
`endif
    check_out("after_timeout", 1'b1, 8'h10, LW'(2), 64'h2211);
    idle(1);

    // Reset mid-frame
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_out("mid_reset", 1'b0, 8'h00, '0, 64'h0);
    check("mid_reset_pulses", {o_chk_err, o_drop, o_timeout}, 3'b000);
    send_basic();
    check_out("after_reset", 1'b1, 8'h10, LW'(2), 64'h2211);
    idle(1);

    // Randomized traffic against the model, with random ready and gaps
    rand_ready = 1'b1;
    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 9);
      q.delete();
      if (kind <= 7) begin
        c8  = 8'($urandom);
        len = (kind == 7) ? $urandom_range(MAXP + 1, 255) : $urandom_range(0, MAXP);
        q.push_back(SYNC);
        q.push_back(c8);
        q.push_back(8'(len));
        x = c8 ^ 8'(len);
        if (kind != 7) begin
          for (int k = 0; k < len; k++) begin
            q.push_back(8'($urandom));
            x ^= q[q.size()-1];
          end
          q.push_back((kind == 6) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
        end
      end else begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) q.push_back(8'($urandom));
      end
      foreach (q[k]) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(q[k]);
      end
      gap = $urandom_range(0, 4);
      if (TO_EN && $urandom_range(0, 15) == 0) gap = TO - 2 + $urandom_range(0, 4);
      idle(gap);
    end
    rand_ready  = 1'b0;
    i_cmd_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame decoder sitting directly downstream of the UART receiver. Consumes its one-cycle byte strobe and byte bus, recognises framed commands (sync, command, length, payload, XOR checksum) and presents each validated command on a valid/ready interface to the smartwatch control logic. Malformed, oversize or back-pressured input is discarded and reported on single-cycle error pulses.

## Interface
- MAX_PAYLOAD, 8: maximum payload bytes per frame (1..255).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 50000: inter-byte timeout in clk cycles (1 ms at 50 MHz). Used only with `UART_CMD_TIMEOUT_EN`.

- clk  in  1  system clock (50 MHz in the reference build).
- rst  in  1  synchronous, active-high reset.
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte is valid.
- i_RX_Byte  in  8  received byte.
- o_cmd_valid  out  1  validated command available; held until accepted.
- i_cmd_ready  in  1  consumer accepts the command when high with o_cmd_valid.
- o_cmd  out  8  command byte.
- o_len  out  $clog2(MAX_PAYLOAD+1)  payload length.
- o_payload  out  8*MAX_PAYLOAD  payload byte k at [8k+7:8k]; bytes at index ≥ o_len are 0.
- o_chk_err  out  1  one-cycle pulse: checksum mismatch.
- o_drop  out  1  one-cycle pulse: LEN > MAX_PAYLOAD, or byte received while in HOLD.
- o_timeout  out  1  one-cycle pulse: partial frame aborted by timeout (tied 0 without the macro).

## Operation
- Frame: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK. CHK = CMD ^ LEN ^ payload[0] ^ … ^ payload[LEN-1].
- Accumulator chk is 8 bits; state advances only on cycles with i_RX_DV=1.
- States:
  - IDLE: byte == SYNC_BYTE → CMD; any other byte discarded silently.
  - CMD: store cmd; chk ← byte; clear payload register to 0 → LEN.
  - LEN: byte > MAX_PAYLOAD → o_drop, IDLE. Otherwise store len, chk ^= byte; len == 0 → CHK; else idx ← 0 → PAYLOAD.
  - PAYLOAD: payload[idx] ← byte, chk ^= byte, idx++; after storing index len-1 → CHK.
  - CHK: byte == chk → HOLD; else o_chk_err, IDLE.
  - HOLD: o_cmd_valid=1; o_cmd/o_len/o_payload stable. When i_cmd_ready=1 → IDLE. Any i_RX_DV in HOLD, including the accepting cycle, pulses o_drop and discards the byte; a SYNC_BYTE here does not start a frame.
- A SYNC_BYTE value inside CMD/LEN/PAYLOAD/CHK is ordinary data. There is no resynchronisation.
- Reset: state IDLE; o_cmd_valid, o_cmd, o_len, o_payload, o_chk_err, o_drop and o_timeout all 0; chk, idx and the timeout counter all 0. Reset mid-frame discards the partial frame with no error pulse.

## Timing
- All outputs are registered.
- o_cmd_valid rises on the cycle after the i_RX_DV cycle carrying a correct CHK.
- Acceptance on a clk edge with o_cmd_valid & i_cmd_ready; o_cmd_valid is 0 on the next cycle. Minimum HOLD duration is 1 cycle.
- o_chk_err, o_drop and o_timeout assert for exactly one cycle, on the cycle after the causing byte or timeout expiry.
- Back-to-back i_RX_DV on consecutive cycles must be handled. The receiver never produces this, but the bench may.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - Counter cleared on every i_RX_DV and while in IDLE or HOLD.
  - In CMD/LEN/PAYLOAD/CHK it increments each cycle without i_RX_DV.
  - On reaching TIMEOUT_CYCLES-1: → IDLE, o_timeout pulse.
  - i_RX_DV in the expiry cycle wins: the byte is processed normally and there is no timeout.
- Not defined: no counter; o_timeout is constant 0; a partial frame waits indefinitely.

## Test plan
- Basic frame: bytes A5 10 02 11 22 21 with i_cmd_ready=1 → o_cmd_valid for 1 cycle; o_cmd=0x10, o_len=2, payload[0]=0x11, payload[1]=0x22, upper bytes 0; no error pulses.
- Zero length plus leading garbage: 00 FF A5 05 00 05 → garbage ignored with no pulses; valid with o_cmd=0x05, o_len=0, o_payload=0.
- Bad checksum: A5 10 01 33 00 (expected 0x22) → one o_chk_err pulse, no valid. An immediately following good frame A5 10 01 33 22 → accepted.
- Oversize and backpressure:
  - A5 01 09 → o_drop, back to IDLE.
  - Valid frame with i_cmd_ready=0, then byte 55 → o_drop, outputs unchanged.
  - Raise i_cmd_ready → one-cycle acceptance.
- Timeout (macro defined, TIMEOUT_CYCLES=100): A5 10, then 100 idle cycles → one o_timeout pulse. The next full frame is accepted. With the macro undefined, the same stimulus gives no pulse, and a later 02 11 22 21 completes the frame.
- Reset mid-frame: A5 10 02 11, pulse rst for 1 cycle → all outputs 0. Then the frame A5 10 02 11 22 21 is accepted correctly.
